// File: rtl/bcd_step_source.sv
// ---------------------------------------------------------------------------
// bcd_step_source
//
// Registered 4-bit digit source for a downstream combinational 4-bit code
// converter. Each step presents a new (or unchanged) digit on a/b/c/d. The
// digit is then held for a settle window, and a one-cycle sample_valid strobe
// tells the next stage that the converter outputs are stable.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   run          in   level; 1 = keep stepping, 0 = stop after current step
//   mode         in   00 hold, 01 count up, 10 count down, 11 load
//   load_val     in   digit to load when mode = 11
//   a,b,c,d      out  digit bits 3..0 (a = MSB) to the converter
//   sample_valid out  one-cycle strobe: converter outputs settled
//   wrap         out  one-cycle pulse: last step wrapped
//   load_err     out  one-cycle pulse: load rejected (load_val > MAX_DIGIT)
//   busy         out  high whenever the sequencer is not idle
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module bcd_step_source #(
    parameter int MAX_DIGIT  = 9,   // legal 1..15
    parameter int SETTLE_CYC = 2    // legal 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [1:0] mode,
    input  logic [3:0] load_val,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       sample_valid,
    output logic       wrap,
    output logic       load_err,
    output logic       busy
);

    localparam logic [3:0] MAX_D       = 4'(MAX_DIGIT);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        STROBE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       sv_q,    sv_d;
    logic       wrap_q,  wrap_d;
    logic       err_q,   err_d;
    logic       busy_q,  busy_d;

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q;
        sv_d    = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = DRIVE;
                end
            end

            // mode is only looked at here; the new digit, wrap and load_err
            // all appear together on the edge leaving DRIVE.
            DRIVE: begin
                cnt_d   = 4'd0;
                state_d = SETTLE;
                case (mode)
                    MODE_UP: begin
                        if (digit_q == MAX_D) begin
                            digit_d = 4'd0;
                            wrap_d  = 1'b1;
                        end else begin
                            digit_d = digit_q + 4'd1;
                        end
                    end
                    MODE_DOWN: begin
                        if (digit_q == 4'd0) begin
                            digit_d = MAX_D;
                            wrap_d  = 1'b1;
                        end else begin
                            digit_d = digit_q - 4'd1;
                        end
                    end
                    MODE_LOAD: begin
                        // Out-of-range loads leave the digit alone so it can
                        // never exceed MAX_DIGIT.
                        if (load_val <= MAX_D) begin
                            digit_d = load_val;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: begin
                        digit_d = digit_q;   // MODE_HOLD: full step, same digit
                    end
                endcase
            end

            // Strobe is registered, so it is raised on the edge that ends the
            // last settle cycle and is therefore visible during STROBE.
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = STROBE;
                    sv_d    = 1'b1;
                end
            end

            STROBE: begin
                state_d = run ? DRIVE : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            digit_q <= 4'd0;
            cnt_q   <= 4'd0;
            sv_q    <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
            sv_q    <= sv_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign a            = digit_q[3];
    assign b            = digit_q[2];
    assign c            = digit_q[1];
    assign d            = digit_q[0];
    assign sample_valid = sv_q;
    assign wrap         = wrap_q;
    assign load_err     = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bcd_step_source.sv
// ---------------------------------------------------------------------------
// tb_bcd_step_source
//
// Bench for bcd_step_source. A step-level reference model (modulo arithmetic
// on integers) predicts the digit, wrap and load_err of each step; the
// expected step period is SETTLE_CYC + 2 cycles. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_step_source;

    localparam int MAX_DIGIT  = 9;
    localparam int SETTLE_CYC = 2;
    localparam int PERIOD     = SETTLE_CYC + 2;
    localparam int LIMIT      = PERIOD + 8;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic       a, b, c, d;
    logic       sample_valid, wrap, load_err, busy;

    int checks   = 0;
    int failures = 0;
    int model_digit = 0;

    bcd_step_source #(
        .MAX_DIGIT (MAX_DIGIT),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mode        (mode),
        .load_val    (load_val),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .sample_valid(sample_valid),
        .wrap        (wrap),
        .load_err    (load_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int digit_now();
        return int'({a, b, c, d});
    endfunction

    // Step-level model: what one completed step does to the digit.
    function automatic void model_step(input int cur, input logic [1:0] m, input int lv,
                                       output int nxt, output int w, output int e);
        nxt = cur; w = 0; e = 0;
        case (m)
            2'b01: begin nxt = (cur + 1) % (MAX_DIGIT + 1); w = (cur + 1 > MAX_DIGIT) ? 1 : 0; end
            2'b10: begin nxt = (cur + MAX_DIGIT) % (MAX_DIGIT + 1); w = (cur == 0) ? 1 : 0; end
            2'b11: begin
                if (lv <= MAX_DIGIT) nxt = lv;
                else e = 1;
            end
            default: nxt = cur;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Runs n steps with run held high. Must be entered either from IDLE or
    // at the falling edge inside a STROBE cycle with run already high.
    task automatic run_steps(input int n, input logic [1:0] m, input int lv, input string tag);
        int exp_d, exp_w, exp_e;
        int cycles, wcnt, ecnt, wpos, held, changed;
        bit got;
        for (int s = 0; s < n; s++) begin
            run      = 1'b1;
            mode     = m;
            load_val = 4'(lv);
            model_step(model_digit, m, lv, exp_d, exp_w, exp_e);
            cycles = 0; wcnt = 0; ecnt = 0; wpos = 0; held = -1; changed = 0; got = 0;
            while (!got && cycles < LIMIT) begin
                tick();
                cycles++;
                if (wrap)     begin wcnt++; wpos = cycles; end
                if (load_err) ecnt++;
                if (cycles == 2) held = digit_now();
                if (cycles > 2 && digit_now() != held) changed = 1;
                if (sample_valid) got = 1;
            end
            checks++;
            if (cycles !== PERIOD || !got) begin
                failures++;
                $display("FAIL %s step%0d period: got %0d cycles (strobe=%0d) need %0d", tag, s, cycles, got, PERIOD);
            end
            checks++;
            if (digit_now() !== exp_d || changed) begin
                failures++;
                $display("FAIL %s step%0d digit: got %0d (unstable=%0d) need %0d", tag, s, digit_now(), changed, exp_d);
            end
            checks++;
            if (wcnt !== exp_w || (exp_w == 1 && wpos != 2)) begin
                failures++;
                $display("FAIL %s step%0d wrap: got %0d pulses at cycle %0d need %0d at cycle 2", tag, s, wcnt, wpos, exp_w);
            end
            checks++;
            if (ecnt !== exp_e) begin
                failures++;
                $display("FAIL %s step%0d load_err: got %0d pulses need %0d", tag, s, ecnt, exp_e);
            end
            model_digit = exp_d;
        end
    endtask

    // Called at the falling edge inside STROBE: drop run, expect IDLE.
    task automatic stop_run(input string tag);
        run = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s stop: busy=%b sample_valid=%b need 0/0", tag, busy, sample_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; mode = 2'b00; load_val = 4'd0;
        tick(); tick();
        checks++;
        if ({a, b, c, d, sample_valid, wrap, load_err, busy} !== 8'b0) begin
            failures++;
            $display("FAIL reset_state: got abcd=%b%b%b%b sv=%b wrap=%b err=%b busy=%b need all 0",
                     a, b, c, d, sample_valid, wrap, load_err, busy);
        end
        rst_n = 1'b1;
        model_digit = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || digit_now() !== 0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b digit=%0d need 0/0", busy, digit_now());
        end
    endtask

    task automatic test_count_up();
        run_steps(12, 2'b01, 0, "up");
        stop_run("up");
    endtask

    task automatic test_count_down();
        run_steps(1, 2'b11, 0, "down_load0");
        run_steps(3, 2'b10, 0, "down");
        stop_run("down");
    endtask

    task automatic test_load();
        run_steps(1, 2'b11, 6, "load6");
        checks++;
        if ({a, b, c, d} !== 4'b0110) begin
            failures++;
            $display("FAIL load6_bits: got %b%b%b%b need 0110", a, b, c, d);
        end
        run_steps(1, 2'b11, 12, "load12");
        run_steps(1, 2'b11, 15, "load15");
        run_steps(1, 2'b11, MAX_DIGIT, "loadmax");
        stop_run("load");
    endtask

    task automatic test_hold();
        run_steps(1, 2'b11, 3, "hold_load3");
        run_steps(3, 2'b00, 0, "hold");
        stop_run("hold");
    endtask

    task automatic test_single_run();
        int strobes = 0;
        int exp_d, exp_w, exp_e;
        model_step(model_digit, 2'b01, 0, exp_d, exp_w, exp_e);
        run = 1'b1; mode = 2'b01;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            tick();
            if (sample_valid) strobes++;
        end
        checks++;
        if (strobes !== 1) begin
            failures++;
            $display("FAIL single_strobes: got %0d need 1", strobes);
        end
        checks++;
        if (busy !== 1'b0 || digit_now() !== exp_d) begin
            failures++;
            $display("FAIL single_idle: busy=%b digit=%0d need 0/%0d", busy, digit_now(), exp_d);
        end
        model_digit = exp_d;
    endtask

    task automatic test_reset_mid_step();
        run = 1'b1; mode = 2'b11; load_val = 4'd5;
        tick(); tick();
        checks++;
        if (digit_now() !== 5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_setup: digit=%0d busy=%b need 5/1", digit_now(), busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a, b, c, d} !== 4'b0000 || sample_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: abcd=%b%b%b%b sv=%b busy=%b need 0000/0/0",
                     a, b, c, d, sample_valid, busy);
        end
        model_digit = 0;
        tick();
        rst_n = 1'b1;
        run_steps(1, 2'b01, 0, "after_reset");
        stop_run("after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_steps(1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), "rand");
        end
        stop_run("rand");
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_hold();
        test_single_run();
        test_reset_mid_step();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
